// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the instruction-store loader and the writable
// instruction memory.
//   D       : instruction address width (memory depth is 2**D words)
//   W       : machine-code word width
//   word_t  : one machine-code word
//   addr_t  : instruction-memory address
//   count_t : load length, 0..2**D inclusive (one bit wider than addr_t)
//   state_t : loader FSM states
//   range_ok: true when a load of cnt words from base stays inside memory
// ---------------------------------------------------------------------------
package instr_pkg;

    localparam int D = 12;
    localparam int W = 9;

    typedef logic [W-1:0] word_t;
    typedef logic [D-1:0] addr_t;
    typedef logic [D:0]   count_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        VERIFY,
        FIN
    } state_t;

    localparam logic [D+1:0] DEPTH = (D+2)'(1 << D);

    // The sum is formed two bits wider than an address so that the largest
    // base plus the largest count can never wrap and look legal.
    function automatic logic range_ok(input addr_t base, input count_t cnt);
        logic [D+1:0] end_excl;
        end_excl = {2'b00, base} + {1'b0, cnt};
        return end_excl <= DEPTH;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// ---------------------------------------------------------------------------
// instr_loader_if
// Word stream and memory bus between the loader and its surroundings.
//   in_valid/in_data/in_ready : incoming machine-code stream (valid/ready)
//   wr_en/wr_addr/wr_data     : write port of the instruction memory
//   rd_addr/rd_data           : shared combinational read port (readback)
// Modports:
//   master : the loader (accepts the stream, drives the memory bus)
//   slave  : the environment (stream source and instruction memory)
// ---------------------------------------------------------------------------
interface instr_loader_if;
    import instr_pkg::*;

    logic  in_valid;
    word_t in_data;
    logic  in_ready;
    logic  wr_en;
    addr_t wr_addr;
    word_t wr_data;
    addr_t rd_addr;
    word_t rd_data;

    modport master (
        input  in_valid, in_data, rd_data,
        output in_ready, wr_en, wr_addr, wr_data, rd_addr
    );

    modport slave (
        output in_valid, in_data, rd_data,
        input  in_ready, wr_en, wr_addr, wr_data, rd_addr
    );

endinterface

// File: rtl/instr_RAM.sv
// ---------------------------------------------------------------------------
// instr_RAM
// Writable instruction memory: synchronous write, combinational read.
// The loader and the fetch unit share the read port; the address mux
// (selected by hold_core) lives outside this block.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid in the same cycle as raddr
// ---------------------------------------------------------------------------
module instr_RAM
    import instr_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    input  addr_t raddr,
    output word_t rdata
);

    word_t mem [0:(1 << D)-1];

    // NOTE: the array has no reset; program contents must survive a core
    // reset, and a resettable array would not map onto block RAM.
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Streams machine-code words into consecutive instruction-memory addresses,
// then reads the region back and compares running XOR checksums. The core
// is held stalled (hold_core) for the whole operation.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   start     : one-cycle load request, honoured only when idle
//   base_addr : first address to write, sampled with start
//   count     : number of words (0..2**D), sampled with start
//   bus       : stream + memory bus (master side)
//   busy      : high in every state except IDLE
//   hold_core : equal to busy; stalls fetch and the program counter
//   done      : one-cycle pulse at the end of an operation
//   pass      : readback matched and no range error (valid with done)
//   range_err : base_addr+count exceeded the memory (valid with done)
//   checksum  : XOR of all accepted words of the current/last load
// ---------------------------------------------------------------------------
module instr_loader
    import instr_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  addr_t           base_addr,
    input  count_t          count,
    instr_loader_if.master  bus,
    output logic            busy,
    output logic            hold_core,
    output logic            done,
    output logic            pass,
    output logic            range_err,
    output word_t           checksum
);

    state_t state_q, state_d;
    addr_t  ptr_q;
    addr_t  base_q;
    count_t count_q;
    count_t remaining_q;
    word_t  wsum_q;
    word_t  rsum_q;
    logic   pass_q;
    logic   range_err_q;

    logic   in_range;
    logic   accept;
    logic   last_step;

    assign in_range  = range_ok(base_addr, count);
    assign last_step = (remaining_q == count_t'(1));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!in_range || count == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept      = 1'b1;
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = ptr_q;
                    bus.wr_data = bus.in_data;
                    if (last_step) begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                bus.rd_addr = ptr_q;
                if (last_step) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            base_q      <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            pass_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        count_q     <= count;
                        ptr_q       <= base_addr;
                        remaining_q <= count;
                        wsum_q      <= '0;
                        rsum_q      <= '0;
                        range_err_q <= !in_range;
                        // An empty in-range load has nothing to verify and
                        // passes trivially.
                        pass_q      <= in_range && (count == '0);
                    end
                end
                WRITE: begin
                    if (accept) begin
                        wsum_q <= wsum_q ^ bus.in_data;
                        if (last_step) begin
                            // Rewind for readback; remaining now counts
                            // verify cycles.
                            ptr_q       <= base_q;
                            remaining_q <= count_q;
                        end else begin
                            ptr_q       <= ptr_q + 1'b1;
                            remaining_q <= remaining_q - 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    rsum_q      <= rsum_q ^ bus.rd_data;
                    ptr_q       <= ptr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    if (last_step) begin
                        // Fold in the final word now so pass is ready in FIN.
                        pass_q <= ((rsum_q ^ bus.rd_data) == wsum_q) && !range_err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign hold_core = busy;
    assign pass      = pass_q;
    assign range_err = range_err_q;
    assign checksum  = wsum_q;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
// Self-checking bench for instr_loader with the instruction RAM attached.
// A transaction-level model (words left to accept, verify cycles left,
// running checksum) predicts every output on every cycle; directed loads
// pin latency, checksums and boundary cases with literal values, and
// randomized loads with random stalls exercise the rest.
// ---------------------------------------------------------------------------
module tb_instr_loader;
    import instr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   reset;
    logic   start;
    addr_t  base_addr;
    count_t count;
    logic   busy, hold_core, done, pass, range_err;
    word_t  checksum;

    addr_t  fetch_addr;
    logic   corrupt_en;
    addr_t  ram_raddr;
    word_t  ram_rdata;

    instr_loader_if bus();

    instr_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .bus       (bus),
        .busy      (busy),
        .hold_core (hold_core),
        .done      (done),
        .pass      (pass),
        .range_err (range_err),
        .checksum  (checksum)
    );

    instr_RAM ram (
        .clk   (clk),
        .we    (bus.wr_en),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Fetch and loader share the read port; hold_core selects the loader.
    assign ram_raddr   = hold_core ? bus.rd_addr : fetch_addr;
    // Optional fault injection: address 1 reads back as 000000001.
    assign bus.rd_data = (corrupt_en && bus.rd_addr == addr_t'(1)) ? word_t'(1) : ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int          wleft;     // words still to accept
        int          vleft;     // readback cycles still to go
        int          cnt;
        int          base;
        int          acc;       // words accepted so far
        bit          fin;
        bit          pass;
        bit          rerr;
        bit          exp_pass;
        bit          hit1;      // address 1 lies in the loaded region
        logic [8:0]  wsum;
        logic [8:0]  w1;        // word stored at address 1
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic rst, logic st, addr_t b,
                                          count_t c, logic v, word_t d, logic cor);
        model_t n;
        n = cur;
        if (rst) begin
            n.wleft = 0; n.vleft = 0; n.cnt = 0; n.base = 0; n.acc = 0;
            n.fin = 0; n.pass = 0; n.rerr = 0; n.exp_pass = 0; n.hit1 = 0;
            n.wsum = '0; n.w1 = '0;
        end else if (cur.fin) begin
            n.fin = 0;
        end else if (cur.vleft > 0) begin
            n.vleft = cur.vleft - 1;
            if (n.vleft == 0) begin
                n.fin  = 1;
                n.pass = cur.exp_pass;
            end
        end else if (cur.wleft > 0) begin
            if (v) begin
                n.wsum = cur.wsum ^ d;
                if ((cur.base + cur.acc) % 4096 == 1) begin
                    n.w1   = d;
                    n.hit1 = 1;
                end
                n.acc   = cur.acc + 1;
                n.wleft = cur.wleft - 1;
                if (n.wleft == 0) begin
                    n.vleft = cur.cnt;
                    // Readback XOR differs from the write XOR only by the
                    // corrupted word's difference.
                    n.exp_pass = !(cor && n.hit1 && n.w1 != 9'd1);
                end
            end
        end else if (st) begin
            n.base = int'(b);
            n.cnt  = int'(c);
            n.acc  = 0;
            n.wsum = '0;
            n.hit1 = 0;
            if (int'(b) + int'(c) > 4096) begin
                n.fin = 1; n.rerr = 1; n.pass = 0;
            end else if (c == '0) begin
                n.fin = 1; n.rerr = 0; n.pass = 1;
            end else begin
                n.wleft = int'(c); n.rerr = 0; n.pass = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, reset, start, base_addr, count, bus.in_valid, bus.in_data, corrupt_en);

    // ---------------- per-cycle compare ----------------
    bit busy_e, acc_e;
    always @(negedge clk) begin
        if (chk_en) begin
            busy_e = (m.wleft > 0) || (m.vleft > 0) || m.fin;
            acc_e  = (m.wleft > 0) && bus.in_valid;
            check("busy",      busy,         busy_e);
            check("hold_core", hold_core,    busy_e);
            check("in_ready",  bus.in_ready, m.wleft > 0);
            check("wr_en",     bus.wr_en,    acc_e);
            check("wr_addr",   bus.wr_addr,  acc_e ? (m.base + m.acc) % 4096 : 0);
            check("wr_data",   bus.wr_data,  acc_e ? bus.in_data : '0);
            check("rd_addr",   bus.rd_addr,  m.vleft > 0 ? (m.base + m.cnt - m.vleft) % 4096 : 0);
            check("done",      done,         m.fin);
            check("checksum",  checksum,     m.wsum);
            if (!busy_e || m.fin) begin
                check("pass",      pass,      m.pass);
                check("range_err", range_err, m.rerr);
            end
        end
    end

    // ---------------- stimulus ----------------
    word_t words [0:15];
    word_t plan_words [0:3];

    // Called at #1 after a rising edge with the loader idle; returns at the
    // same phase one cycle after done.
    task automatic do_load(input int b, input int c, input int gap_len, input bit rnd_stall,
                           input bit cor, output int lat, output bit p, output bit re,
                           output word_t cs);
        int k;
        int gap;
        int t0;
        k   = 0;
        gap = gap_len;
        lat = -1;
        p   = 1'b0;
        re  = 1'b0;
        cs  = '0;
        start      = 1'b1;
        base_addr  = addr_t'(b);
        count      = count_t'(c);
        corrupt_en = cor;
        bus.in_valid = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            // Stray requests while busy must be ignored.
            start     = ($urandom_range(0, 4) == 0);
            base_addr = addr_t'($urandom);
            count     = count_t'($urandom);
            if (k < c) begin
                if (k == 2 && gap > 0) begin
                    bus.in_valid = 1'b0;
                    gap--;
                end else begin
                    bus.in_valid = !(rnd_stall && $urandom_range(0, 2) == 0);
                end
                bus.in_data = words[k];
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = word_t'($urandom);
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            if (done) begin
                lat = cyc - t0;
                p   = pass;
                re  = range_err;
                cs  = checksum;
                break;
            end
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        check("load_done_seen", lat >= 0, 1);
        @(posedge clk); #1;
    endtask

    int    lat;
    bit    p, re;
    word_t cs;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        count        = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        fetch_addr   = '0;
        corrupt_en   = 1'b0;

        plan_words[0] = 9'b001111110;
        plan_words[1] = 9'b001100110;
        plan_words[2] = 9'b001111010;
        plan_words[3] = 9'b111011110;

        @(posedge clk); #1;
        chk_en = 1'b1;              // reset state is compared while reset is held
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back load of four words at address 0.
        for (int i = 0; i < 4; i++) words[i] = plan_words[i];
        do_load(0, 4, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("plain_latency",  lat, 9);
        check("plain_pass",     p,   1);
        check("plain_checksum", cs,  9'h1BC);
        for (int i = 0; i < 4; i++) begin
            fetch_addr = addr_t'(i);
            #1;
            check("fetch_read", ram_rdata, plan_words[i]);
        end
        fetch_addr = '0;

        // Three-cycle stall after the second word.
        do_load(0, 4, 3, 1'b0, 1'b0, lat, p, re, cs);
        check("stall_latency", lat, 12);
        check("stall_pass",    p,   1);

        // Load ending on the last address.
        words[0] = 9'h0A5;
        words[1] = 9'h15A;
        do_load(4094, 2, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("top_pass",     p,  1);
        check("top_checksum", cs, 9'h1FF);

        // One word past the end is rejected.
        do_load(4095, 2, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("range_latency", lat, 1);
        check("range_err",     re,  1);
        check("range_pass",    p,   0);

        // Full-depth count from a nonzero base is rejected too.
        do_load(1, 4096, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("range_full_err", re, 1);

        // Empty load.
        do_load(77, 0, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("empty_latency",  lat, 1);
        check("empty_pass",     p,   1);
        check("empty_checksum", cs,  0);

        // Corrupted readback of address 1.
        for (int i = 0; i < 4; i++) words[i] = plan_words[i];
        do_load(0, 4, 0, 1'b0, 1'b1, lat, p, re, cs);
        check("corrupt_pass", p, 0);
        corrupt_en = 1'b0;

        // Reset on the second accepted word of an eight-word load.
        for (int i = 0; i < 8; i++) words[i] = word_t'($urandom);
        start     = 1'b1;
        base_addr = addr_t'(100);
        count     = count_t'(8);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start        = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = words[k];
            if (k == 1) reset = 1'b1;
            @(negedge clk);
            if (reset) break;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",     busy,         0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_done",     done,         0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) words[i] = plan_words[i];
        do_load(0, 4, 0, 1'b0, 1'b0, lat, p, re, cs);
        check("after_rst_pass",     p,  1);
        check("after_rst_checksum", cs, 9'h1BC);

        // Randomized loads with random stalls, boundaries and corruption.
        for (int n = 0; n < 30; n++) begin
            int b, c;
            bit cor;
            b   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4095))
                                               : int'($urandom_range(4085, 4095));
            c   = int'($urandom_range(0, 12));
            cor = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) words[i] = word_t'($urandom);
            do_load(b, c, 0, 1'b1, cor, lat, p, re, cs);
            corrupt_en = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
